collision_matrix_ctrl: RTL

Parametrised collision arbiter for the VGA game pipeline. It takes one drawing-request bit per object layer, evaluates every enabled object pair on each pixel clock, and produces three things:
- per-pair single-pulse hits, at most one per pair per frame;
- a per-frame hit summary;
- a buffered event queue that game logic drains at its own pace.

It sits between the object drawers and the game state machines, replacing fixed two-signal collision wiring.

---
 rtl/collision_matrix_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/collision_matrix_ctrl.sv
// collision_matrix_ctrl: pairwise collision arbiter for the VGA game pipeline.
// Evaluates every enabled object pair per pixel, emits one hit pulse per pair per
// frame, a per-frame hit summary and a buffered event queue for game logic.
// Optional feature: define COLLISION_PIXEL_COUNT_EN for per-pair overlap pixel counters.
module collision_matrix_ctrl #(
    parameter int unsigned NUM_OBJ    = 6,
    parameter logic [63:0] PAIR_MASK  = '1,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_OBJ-1:0]   draw_req,
    output logic                 collision_any,
    output logic [NUM_PAIRS-1:0] hit_pulse,
    output logic [NUM_PAIRS-1:0] frame_hits,
    output logic                 frame_valid,
    output logic                 evt_valid,
    output logic [5:0]           evt_pair,
    input  logic                 evt_ready,
`ifdef COLLISION_PIXEL_COUNT_EN
    input  logic [5:0]           pix_sel,
    output logic [11:0]          pix_count,
`endif
    output logic [7:0]           evt_merged
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [NUM_PAIRS-1:0] overlap;
    logic [NUM_PAIRS-1:0] new_hit;
    logic [NUM_PAIRS-1:0] issue_sel;
    logic [5:0]           issue_idx;
    logic                 issue_found;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 merge_any;

    logic                 collision_any_q, collision_any_d;
    logic [NUM_PAIRS-1:0] hit_pulse_q, hit_pulse_d;
    logic [NUM_PAIRS-1:0] cur_hit_q, cur_hit_d;
    logic [NUM_PAIRS-1:0] frame_hits_q, frame_hits_d;
    logic                 frame_valid_q, frame_valid_d;
    logic [NUM_PAIRS-1:0] pending_q, pending_d;
    logic [7:0]           merged_q, merged_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [5:0]           mem_q [FIFO_DEPTH];
    logic [5:0]           mem_d [FIFO_DEPTH];

    // Pair k enumerates (i,j), i<j, lexicographically.
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_col
            localparam int unsigned K = gi * (2 * NUM_OBJ - gi - 1) / 2 + (gj - gi - 1);
            assign overlap[K] = draw_req[gi] & draw_req[gj] & PAIR_MASK[K];
        end
    end

    assign new_hit   = overlap & ~cur_hit_q;
    assign merge_any = |(new_hit & pending_q);
    assign full      = (wr_ptr_q - rd_ptr_q) == (AW + 1)'(FIFO_DEPTH);
    assign evt_valid = wr_ptr_q != rd_ptr_q;
    assign pop       = evt_valid & evt_ready;
    assign push      = issue_found & (~full | pop);
    assign evt_pair  = mem_q[rd_ptr_q[AW-1:0]];

    // Pick the lowest-index pending pair as the next event to enqueue.
    always_comb begin
        issue_found = 1'b0;
        issue_sel   = '0;
        issue_idx   = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (pending_q[k] && !issue_found) begin
                issue_found  = 1'b1;
                issue_sel[k] = 1'b1;
                issue_idx    = 6'(k);
            end
        end
    end

    // Next-state for frame latches, pending vector, merge counter and event FIFO.
    always_comb begin
        collision_any_d = |overlap;
        hit_pulse_d     = new_hit;
        frame_valid_d   = startOfFrame;
        frame_hits_d    = startOfFrame ? (cur_hit_q | overlap) : frame_hits_q;
        // The startOfFrame overlap closes the old frame and is not carried forward.
        cur_hit_d       = startOfFrame ? '0 : (cur_hit_q | overlap);
        // A hit on an already-pending pair is merged rather than re-queued.
        pending_d       = (pending_q & ~(push ? issue_sel : '0)) | (new_hit & ~pending_q);
        merged_d        = (merge_any && merged_q != 8'hFF) ? merged_q + 8'd1 : merged_q;
        wr_ptr_d        = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d        = rd_ptr_q + (AW + 1)'(pop);
        mem_d           = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = issue_idx;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision_any_q <= 1'b0;
            hit_pulse_q     <= '0;
            cur_hit_q       <= '0;
            frame_hits_q    <= '0;
            frame_valid_q   <= 1'b0;
            pending_q       <= '0;
            merged_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            collision_any_q <= collision_any_d;
            hit_pulse_q     <= hit_pulse_d;
            cur_hit_q       <= cur_hit_d;
            frame_hits_q    <= frame_hits_d;
            frame_valid_q   <= frame_valid_d;
            pending_q       <= pending_d;
            merged_q        <= merged_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            mem_q           <= mem_d;
        end
    end

    assign collision_any = collision_any_q;
    assign hit_pulse     = hit_pulse_q;
    assign frame_hits    = frame_hits_q;
    assign frame_valid   = frame_valid_q;
    assign evt_merged    = merged_q;

`ifdef COLLISION_PIXEL_COUNT_EN
    logic [11:0] pix_cnt_q [NUM_PAIRS];
    logic [11:0] pix_cnt_d [NUM_PAIRS];
    logic [11:0] pix_snap_q [NUM_PAIRS];
    logic [11:0] pix_snap_d [NUM_PAIRS];
    logic [11:0] pix_count_q, pix_count_d;
    logic [11:0] pix_sum;

    // Saturating per-pair overlap counters, snapshotted and cleared at frame start.
    always_comb begin
        pix_sum     = '0;
        pix_count_d = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            pix_sum = (overlap[k] && pix_cnt_q[k] != 12'hFFF) ? pix_cnt_q[k] + 12'd1
                                                              : pix_cnt_q[k];
            pix_snap_d[k] = startOfFrame ? pix_sum : pix_snap_q[k];
            pix_cnt_d[k]  = startOfFrame ? 12'd0 : pix_sum;
            if (pix_sel == 6'(k)) begin
                pix_count_d = pix_snap_q[k];
            end
        end
    end

    // Pixel counter registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pix_count_q <= '0;
            for (int k = 0; k < NUM_PAIRS; k++) begin
                pix_cnt_q[k]  <= '0;
                pix_snap_q[k] <= '0;
            end
        end else begin
            pix_count_q <= pix_count_d;
            pix_cnt_q   <= pix_cnt_d;
            pix_snap_q  <= pix_snap_d;
        end
    end

    assign pix_count = pix_count_q;
`endif

endmodule
